// File: rtl/cpu_bus.sv
// cpu_bus: memory-side bus stage behind the 16-bit CPU memory port.
// Splits CPU traffic between an external synchronous block RAM and a
// 16-word IO window. The window holds a TX byte FIFO with a valid/ready
// drain port, a snapshot-able 32-bit free-running cycle counter and an
// LED register. Read data is valid exactly one cycle after the read
// address is presented, and the bus never stalls.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cpu_raddr_i/cpu_rd_i  CPU read address / read strobe
//   cpu_rdata_o           data for the address presented last cycle
//   cpu_waddr_i/cpu_wdata_i/cpu_wr_i  CPU write port (commits at the edge)
//   ram_raddr_o/ram_rdata_i           RAM read port (RAM has 1-cycle latency)
//   ram_waddr_o/ram_wdata_o/ram_wr_o  RAM write port (IO writes masked off)
//   tx_data_o/tx_valid_o/tx_ready_i   TX FIFO drain port
//   led_o                 LED register
module cpu_bus #(
  parameter int                AWIDTH  = 16,
  parameter int                DWIDTH  = 16,
  parameter logic [AWIDTH-1:0] IO_BASE = 16'hF000,
  parameter int                FIFO_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] cpu_raddr_i,
  input  logic              cpu_rd_i,
  output logic [DWIDTH-1:0] cpu_rdata_o,
  input  logic [AWIDTH-1:0] cpu_waddr_i,
  input  logic [DWIDTH-1:0] cpu_wdata_i,
  input  logic              cpu_wr_i,
  output logic [AWIDTH-1:0] ram_raddr_o,
  input  logic [DWIDTH-1:0] ram_rdata_i,
  output logic [AWIDTH-1:0] ram_waddr_o,
  output logic [DWIDTH-1:0] ram_wdata_o,
  output logic              ram_wr_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic [7:0]        led_o
);

  localparam logic [3:0] OFF_TXDATA = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_CNT_LO = 4'd2;
  localparam logic [3:0] OFF_CNT_HI = 4'd3;
  localparam logic [3:0] OFF_LED    = 4'd4;

  localparam logic [FIFO_AW:0]   DEPTH     = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   CNT_ONE   = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]   CNT_ZERO  = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW-1:0] PTR_ONE   = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ZERO  = {FIFO_AW{1'b0}};
  localparam int                 DEPTH_N   = int'(DEPTH);
  localparam logic [DWIDTH-1:0]  DATA_ZERO = {DWIDTH{1'b0}};

  // Address decode
  logic       raddr_io;
  logic       waddr_io;
  logic       io_wr;
  logic [3:0] roff;
  logic [3:0] woff;

  // TX FIFO state
  logic [7:0]         fifo_mem [0:DEPTH_N-1];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic               full;
  logic               empty;
  logic               push_req;
  logic               push;
  logic               pop;
  logic               status_clr;

  // Counter, LED and read path
  logic [31:0]       counter;
  logic [31:0]       snapshot;
  logic [7:0]        led;
  logic              sel_io;
  logic [DWIDTH-1:0] io_rdata;
  logic [DWIDTH-1:0] io_rd_mux;

  assign raddr_io = (cpu_raddr_i[AWIDTH-1:4] == IO_BASE[AWIDTH-1:4]);
  assign waddr_io = (cpu_waddr_i[AWIDTH-1:4] == IO_BASE[AWIDTH-1:4]);
  assign roff     = cpu_raddr_i[3:0];
  assign woff     = cpu_waddr_i[3:0];
  assign io_wr    = cpu_wr_i & waddr_io;

  // RAM side is a pure pass-through; only the write strobe is gated so
  // IO stores never land in RAM.
  assign ram_raddr_o = cpu_raddr_i;
  assign ram_waddr_o = cpu_waddr_i;
  assign ram_wdata_o = cpu_wdata_i;
  assign ram_wr_o    = cpu_wr_i & ~waddr_io;

  // full/empty come from registered state only, so a same-cycle pop never
  // makes room for a push.
  assign full       = (count == DEPTH);
  assign empty      = (count == CNT_ZERO);
  assign push_req   = io_wr & (woff == OFF_TXDATA);
  assign push       = push_req & ~full;
  assign pop        = tx_valid_o & tx_ready_i;
  assign status_clr = io_wr & (woff == OFF_STATUS) & cpu_wdata_i[2];

  assign tx_valid_o  = ~empty;
  assign tx_data_o   = fifo_mem[rptr];
  assign led_o       = led;
  assign cpu_rdata_o = sel_io ? io_rdata : ram_rdata_i;

  // IO register read mux, evaluated on pre-edge state so a same-cycle
  // write is not visible to the read.
  always_comb begin
    io_rd_mux = DATA_ZERO;
    case (roff)
      OFF_TXDATA: io_rd_mux = DATA_ZERO;
      OFF_STATUS: io_rd_mux = DWIDTH'({4'b0000, 4'(count), 5'b00000, overflow, empty, full});
      OFF_CNT_LO: io_rd_mux = DWIDTH'(snapshot[15:0]);
      OFF_CNT_HI: io_rd_mux = DWIDTH'(snapshot[31:16]);
      OFF_LED:    io_rd_mux = DWIDTH'(led);
      default:    io_rd_mux = DATA_ZERO;
    endcase
  end

  // Read-source select and IO read data, captured only on read strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_io   <= 1'b0;
      io_rdata <= DATA_ZERO;
    end else if (cpu_rd_i) begin
      sel_io   <= raddr_io;
      io_rdata <= io_rd_mux;
    end
  end

  // Free-running cycle counter; a CNT_LO write captures the pre-increment value.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter  <= 32'd0;
      snapshot <= 32'd0;
    end else begin
      counter <= counter + 32'd1;
      if (io_wr && (woff == OFF_CNT_LO)) begin
        snapshot <= counter;
      end
    end
  end

  // LED register.
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= 8'h00;
    end else if (io_wr && (woff == OFF_LED)) begin
      led <= cpu_wdata_i[7:0];
    end
  end

  // TX FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= PTR_ZERO;
      rptr     <= PTR_ZERO;
      count    <= CNT_ZERO;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH_N; i++) begin
        fifo_mem[i] <= 8'h00;
      end
    end else begin
      if (push) begin
        fifo_mem[wptr] <= cpu_wdata_i[7:0];
        wptr           <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // A dropped push wins over a same-cycle clear.
      if (push_req && full) begin
        overflow <= 1'b1;
      end else if (status_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
